// File: rtl/mem_copy_sched_pkg.sv
// mem_copy_sched_pkg: FSM encoding and default widths shared by the BRAM copy scheduler
package mem_copy_sched_pkg;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;
  localparam int DEF_LW = DEF_AW + 1;
  typedef enum logic [2:0] {S_IDLE, S_COPY, S_DRAIN, S_VERIFY, S_VDRAIN, S_DONE} state_t;
endpackage

// File: rtl/mem_copy_sched_rr_arbiter.sv
// rr_arbiter: round-robin picker; search starts at the pointer, pointer moves past the winner on accept
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);
  logic [IW-1:0] r_ptr, w_k;
  // descending scan so the lowest offset from the pointer wins
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    w_k = '0;
    for (int o = N - 1; o >= 0; o--) begin
      w_k = IW'((32'(r_ptr) + 32'(o)) % 32'(N));
      if (i_req[w_k]) begin
        o_idx = w_k;
        o_any = 1'b1;
      end
    end
  end
  assign o_gnt = o_any ? N'(1) << o_idx : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (i_accept) r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/mem_copy_sched.sv
// mem_copy_sched: round-robin job scheduler that copies a BRAM region, then verifies it by readback
module mem_copy_sched
  import mem_copy_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int LW = DEF_LW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_src,
  input  logic [NREQ*AW-1:0] req_dst,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic             err,
  output logic             busy,
  output logic             src_en,
  output logic [AW-1:0]    src_addr,
  input  logic [DW-1:0]    src_dout,
  output logic             dst_en,
  output logic             dst_we,
  output logic [AW-1:0]    dst_addr,
  output logic [DW-1:0]    dst_din,
  input  logic [DW-1:0]    dst_dout
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  state_t r_st, w_nst;
  logic r_busy, r_mis, r_cv;
  logic [NREQ-1:0] r_gnt, r_own, w_pick;
  logic [IW-1:0] w_idx;
  logic [AW-1:0] r_src, r_dst, w_i, w_lm1;
  logic [LW-1:0] r_len, r_i;
  logic w_any, w_acc, w_last, w_step, w_wr;
  // the grant cycle itself is spent in IDLE with busy already set
  assign w_acc = (r_st == S_IDLE) && !r_busy && w_any;
  assign w_last = r_i == r_len - 1'b1;
  assign w_i = r_i[AW-1:0];
  assign w_lm1 = AW'(r_len - 1'b1);
  assign w_wr = r_i != '0;
  assign w_step = ((r_st == S_COPY) || (r_st == S_VERIFY)) && !w_last;
  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(req),
    .i_accept(w_acc),
    .o_gnt(w_pick),
    .o_idx(w_idx),
    .o_any(w_any)
  );
  always_comb begin
    w_nst = r_st;
    src_en = 1'b0;
    src_addr = '0;
    dst_en = 1'b0;
    dst_we = 1'b0;
    dst_addr = '0;
    dst_din = '0;
    case (r_st)
      S_IDLE: w_nst = r_busy ? ((r_len == '0) ? S_DONE : S_COPY) : S_IDLE;
      S_COPY: begin
        w_nst = w_last ? S_DRAIN : S_COPY;
        src_en = 1'b1;
        src_addr = r_src + w_i;
        dst_en = w_wr;
        dst_we = w_wr;
        dst_addr = w_wr ? r_dst + w_i - 1'b1 : '0;
        dst_din = w_wr ? src_dout : '0;
      end
      S_DRAIN: begin
        w_nst = S_VERIFY;
        dst_en = 1'b1;
        dst_we = 1'b1;
        dst_addr = r_dst + w_lm1;
        dst_din = src_dout;
      end
      S_VERIFY: begin
        w_nst = w_last ? S_VDRAIN : S_VERIFY;
        src_en = 1'b1;
        dst_en = 1'b1;
        src_addr = r_src + w_i;
        dst_addr = r_dst + w_i;
      end
      S_VDRAIN: w_nst = S_DONE;
      S_DONE: w_nst = S_IDLE;
      default: w_nst = S_IDLE;
    endcase
  end
  assign gnt = r_gnt;
  assign done = (r_st == S_DONE) ? r_own : '0;
  assign err = (r_st == S_DONE) && r_mis;
  assign busy = r_busy;
  // r_cv marks cycles whose read data came from a VERIFY read one cycle earlier
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_st <= S_IDLE;
      r_busy <= 1'b0;
      r_mis <= 1'b0;
      r_cv <= 1'b0;
      r_gnt <= '0;
      r_own <= '0;
      r_src <= '0;
      r_dst <= '0;
      r_len <= '0;
      r_i <= '0;
    end else begin
      r_st <= w_nst;
      r_gnt <= w_acc ? w_pick : '0;
      r_cv <= r_st == S_VERIFY;
      r_i <= w_step ? r_i + 1'b1 : '0;
      if (w_acc) begin
        r_busy <= 1'b1;
        r_mis <= 1'b0;
        r_own <= w_pick;
        r_src <= req_src[w_idx*AW +: AW];
        r_dst <= req_dst[w_idx*AW +: AW];
        r_len <= req_len[w_idx*LW +: LW];
      end else if (r_st == S_DONE) r_busy <= 1'b0;
      if (r_cv && (src_dout != dst_dout)) r_mis <= 1'b1;
    end
endmodule

// File: tb/tb_mem_copy_sched.sv
// tb_mem_copy_sched: random and directed jobs against a queue-based per-cycle model of the scheduler
module tb_mem_copy_sched;
  localparam int NREQ = 2, AW = 8, DW = 16, LW = 9;
  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic err;
    logic busy;
    logic src_en;
    logic [AW-1:0] src_addr;
    logic dst_en;
    logic dst_we;
    logic [AW-1:0] dst_addr;
    logic [DW-1:0] dst_din;
  } obs_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0] req = '0;
  logic [NREQ*AW-1:0] req_src = '0, req_dst = '0;
  logic [NREQ*LW-1:0] req_len = '0;
  logic [NREQ-1:0] gnt, done;
  logic err, busy, src_en, dst_en, dst_we;
  logic [AW-1:0] src_addr, dst_addr;
  logic [DW-1:0] dst_din;
  logic [DW-1:0] src_dout = '0, dst_dout = '0;
  logic [DW-1:0] src_mem [256];
  logic [DW-1:0] dst_mem [256];
  int inj_addr = -1;
  obs_t q[$];
  int m_ptr = 0;
  bit m_free = 1'b1;
  int checks = 0, errors = 0, cyc = 0;
  int gnt_cyc, done_cyc, we_cnt, act_cnt;
  logic [NREQ-1:0] last_done;
  logic last_err;
  logic [NREQ-1:0] gnt_log[$];
  logic [AW-1:0] src_log[$];

  mem_copy_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_src(req_src), .req_dst(req_dst), .req_len(req_len),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .src_en(src_en), .src_addr(src_addr), .src_dout(src_dout),
    .dst_en(dst_en), .dst_we(dst_we), .dst_addr(dst_addr), .dst_din(dst_din), .dst_dout(dst_dout)
  );

  always #5 clk = ~clk;

  // BRAMs with one-cycle read latency; inj_addr corrupts destination reads only
  always @(posedge clk) begin
    if (src_en) src_dout <= src_mem[src_addr];
    if (dst_en && dst_we) dst_mem[dst_addr] <= dst_din;
    if (dst_en && !dst_we) dst_dout <= (int'(dst_addr) == inj_addr) ? 16'hDEAD : dst_mem[dst_addr];
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Builds the whole cycle-by-cycle bus picture of one job from the copy/verify rules
  task automatic model_grant();
    int k, l;
    logic [AW-1:0] s, d;
    obs_t e;
    k = -1;
    for (int o = NREQ - 1; o >= 0; o--) if (req[(m_ptr + o) % NREQ]) k = (m_ptr + o) % NREQ;
    if (k < 0) return;
    m_ptr = (k + 1) % NREQ;
    s = req_src[k*AW +: AW];
    d = req_dst[k*AW +: AW];
    l = int'(req_len[k*LW +: LW]);
    e = '0; e.gnt = NREQ'(1) << k; e.busy = 1'b1; q.push_back(e);
    for (int i = 0; i < l; i++) begin
      e = '0; e.busy = 1'b1; e.src_en = 1'b1; e.src_addr = s + AW'(i);
      if (i > 0) begin
        e.dst_en = 1'b1; e.dst_we = 1'b1; e.dst_addr = d + AW'(i - 1); e.dst_din = src_mem[s + AW'(i - 1)];
      end
      q.push_back(e);
    end
    if (l > 0) begin
      e = '0; e.busy = 1'b1; e.dst_en = 1'b1; e.dst_we = 1'b1;
      e.dst_addr = d + AW'(l - 1); e.dst_din = src_mem[s + AW'(l - 1)]; q.push_back(e);
      for (int i = 0; i < l; i++) begin
        e = '0; e.busy = 1'b1; e.src_en = 1'b1; e.dst_en = 1'b1;
        e.src_addr = s + AW'(i); e.dst_addr = d + AW'(i); q.push_back(e);
      end
      e = '0; e.busy = 1'b1; q.push_back(e);
    end
    e = '0; e.busy = 1'b1; e.done = NREQ'(1) << k;
    e.err = (l > 0) && (inj_addr >= 0) && (((inj_addr - int'(d)) & 255) < l);
    q.push_back(e);
  endtask

  task automatic tick();
    obs_t a, e;
    bit has;
    if (rst_n && m_free) model_grant();
    @(posedge clk);
    #1;
    req = req & ~gnt;
    @(negedge clk);
    cyc++;
    a = {gnt, done, err, busy, src_en, src_addr, dst_en, dst_we, dst_addr, dst_din};
    if (!rst_n) begin
      q.delete(); m_ptr = 0; m_free = 1'b1; e = '0;
    end else begin
      has = q.size() > 0;
      e = has ? q.pop_front() : '0;
      m_free = !has;
    end
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs cyc %0d: got gnt=%b done=%b err=%b busy=%b src=%b/%h dst=%b/%b/%h/%h, want gnt=%b done=%b err=%b busy=%b src=%b/%h dst=%b/%b/%h/%h",
        cyc, a.gnt, a.done, a.err, a.busy, a.src_en, a.src_addr, a.dst_en, a.dst_we, a.dst_addr, a.dst_din,
        e.gnt, e.done, e.err, e.busy, e.src_en, e.src_addr, e.dst_en, e.dst_we, e.dst_addr, e.dst_din);
    end
    if (gnt != '0) begin gnt_cyc = cyc; gnt_log.push_back(gnt); end
    if (done != '0) begin done_cyc = cyc; last_done = done; last_err = err; end
    we_cnt += int'(dst_we);
    act_cnt += int'(src_en | dst_en);
    if (src_en) src_log.push_back(src_addr);
  endtask

  task automatic clear_obs();
    gnt_cyc = -1; done_cyc = -1; we_cnt = 0; act_cnt = 0;
    last_done = '0; last_err = 1'b0;
    gnt_log.delete(); src_log.delete();
  endtask

  task automatic start(int k, int s, int d, int l);
    req_src[k*AW +: AW] = AW'(s);
    req_dst[k*AW +: AW] = AW'(d);
    req_len[k*LW +: LW] = LW'(l);
    req[k] = 1'b1;
  endtask

  task automatic run_idle(int budget);
    int n = 0;
    do begin tick(); n++; end while ((req != '0 || q.size() > 0 || busy) && n < budget);
    chk("idle_bound", int'(n < budget), 1);
  endtask

  function automatic int glog(int i);
    return (gnt_log.size() > i) ? int'(gnt_log[i]) : -1;
  endfunction

  function automatic int slog(int i);
    return (src_log.size() > i) ? int'(src_log[i]) : -1;
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 256; i++) src_mem[i] = DW'($urandom_range(0, 32'hDEAC));
    for (int i = 0; i < 4; i++) src_mem[8'h10 + i] = 16'hA000 + 16'(i);
    src_mem[8'h30] = 16'h1111; src_mem[8'h31] = 16'h2222; src_mem[8'h32] = 16'h3333;
    clear_obs();
    repeat (3) tick();
    rst_n = 1'b1;
    // simultaneous requests from the reset pointer
    clear_obs(); start(0, 'h20, 'hA0, 2); start(1, 'h24, 'hB0, 2);
    run_idle(100);
    chk("cont_first", glog(0), 1);
    chk("cont_second", glog(1), 2);
    // single job, fixed latency and copied data
    clear_obs(); start(0, 'h10, 'h80, 4);
    run_idle(100);
    chk("single_gnt", glog(0), 1);
    chk("single_lat", done_cyc - gnt_cyc, 11);
    chk("single_done", int'(last_done), 1);
    chk("single_err", int'(last_err), 0);
    chk("single_we", we_cnt, 4);
    for (int i = 0; i < 4; i++) chk("single_data", int'(dst_mem[8'h80 + i]), 'hA000 + i);
    // pointer now sits at requester 1
    clear_obs(); start(0, 'h50, 'hC0, 3); start(1, 'h58, 'hD0, 1);
    run_idle(200);
    chk("rot_first", glog(0), 2);
    chk("rot_second", glog(1), 1);
    // zero-length job
    clear_obs(); start(0, 'h60, 'h70, 0);
    run_idle(20);
    chk("zero_lat", done_cyc - gnt_cyc, 1);
    chk("zero_done", int'(last_done), 1);
    chk("zero_err", int'(last_err), 0);
    chk("zero_act", act_cnt, 0);
    // address wrap-around
    clear_obs(); start(1, 'hFE, 'h02, 4);
    run_idle(100);
    chk("wrap_n", src_log.size(), 8);
    chk("wrap_a0", slog(0), 'hFE);
    chk("wrap_a1", slog(1), 'hFF);
    chk("wrap_a2", slog(2), 'h00);
    chk("wrap_a3", slog(3), 'h01);
    for (int i = 0; i < 4; i++) chk("wrap_data", int'(dst_mem[2 + i]), int'(src_mem[8'hFE + 8'(i)]));
    chk("wrap_err", int'(last_err), 0);
    // corrupted readback of the second destination word
    clear_obs(); inj_addr = 'h41; start(0, 'h30, 'h40, 3);
    run_idle(100);
    chk("mis_lat", done_cyc - gnt_cyc, 9);
    chk("mis_err", int'(last_err), 1);
    inj_addr = -1;
    // random traffic checked cycle by cycle against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NREQ; k++)
        if (!req[k] && $urandom_range(0, 7) == 0)
          start(k, $urandom_range(0, 255), $urandom_range(0, 255),
                ($urandom_range(0, 31) == 0) ? 256 : $urandom_range(0, 12));
      tick();
    end
    run_idle(2000);
    // reset in the middle of a copy
    clear_obs(); start(0, 'h00, 'h90, 8);
    n = 0;
    while (gnt_log.size() == 0 && n < 20) begin tick(); n++; end
    chk("mid_gnt", glog(0), 1);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_outs", int'({gnt, done, err, busy, src_en, dst_en, dst_we, src_addr, dst_addr, dst_din} != '0), 0);
    done_cyc = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    chk("rst_no_done", done_cyc, -1);
    clear_obs(); start(0, 'h08, 'hE0, 2); start(1, 'h0C, 'hE8, 2);
    run_idle(100);
    chk("rst_ptr", glog(0), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
